// File: rtl/data_cache.sv
// data_cache -- direct-mapped, write-through, no-write-allocate data cache.
//
// Sits between the controller/datapath and main data memory. One byte per
// line; each line holds a valid bit, a tag and one data byte. Loads that hit
// complete in the same cycle with busy low. Every other request raises busy
// until it has finished, so the PC stalls.
//
// Optional feature macro: DATA_CACHE_STATS_EN. When it is defined, the
// hit_count/miss_count outputs and their saturating counters are added.
//
// Ports
//   clock       single clock, all state on posedge
//   reset       synchronous, active-low
//   addr        byte address from datapath
//   WriteData   store data
//   MemRead     load request
//   MemWrite    store request (wins over MemRead)
//   ReadData    load data, valid when MemRead && !busy (0 otherwise)
//   busy        request not yet complete; CPU holds its inputs stable
//   mem_addr    main-memory address
//   mem_wdata   main-memory write data
//   mem_req     main-memory request
//   mem_we      1 = write, 0 = read (valid with mem_req)
//   mem_rdata   main-memory read data (valid with mem_ack on reads)
//   mem_ack     one-cycle completion pulse from main memory
//   hit_count   (stats build) loads resolved as hits, saturating
//   miss_count  (stats build) loads resolved as misses, saturating
//   state_dbg   current FSM state, for observation only
//
// Memory handshake: mem_req rises in the first FILL/WRITE cycle. From then
// on, mem_req, mem_we, mem_addr and mem_wdata hold steady until the cycle in
// which mem_ack is sampled high. mem_req is low in the cycle after that.
// mem_ack seen in any other state is ignored.

module data_cache #(
  parameter int NBITS  = 8,
  parameter int NLINES = 8   // power of two, at least 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [NBITS-1:0] addr,
  input  logic [NBITS-1:0] WriteData,
  input  logic             MemRead,
  input  logic             MemWrite,
  output logic [NBITS-1:0] ReadData,
  output logic             busy,
  output logic [NBITS-1:0] mem_addr,
  output logic [NBITS-1:0] mem_wdata,
  output logic             mem_req,
  output logic             mem_we,
  input  logic [NBITS-1:0] mem_rdata,
  input  logic             mem_ack,
`ifdef DATA_CACHE_STATS_EN
  output logic [15:0]      hit_count,
  output logic [15:0]      miss_count,
`endif
  output logic [1:0]       state_dbg
);

  localparam int IDX = $clog2(NLINES);
  localparam int TAG = NBITS - IDX;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_WRITE = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [NLINES-1:0] valid_q;
  logic [TAG-1:0]    tag_q  [NLINES];
  logic [NBITS-1:0]  data_q [NLINES];

  logic [IDX-1:0]    idx;
  logic [TAG-1:0]    atag;
  logic              hit;

  assign idx  = addr[IDX-1:0];
  assign atag = addr[NBITS-1:IDX];
  assign hit  = valid_q[idx] && (tag_q[idx] == atag);

  assign state_dbg = state_q;

  // Next state and outputs
  always_comb begin
    state_d   = state_q;
    busy      = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    ReadData  = '0;
    case (state_q)
      S_IDLE: begin
        if (MemWrite) begin
          busy    = 1'b1;
          state_d = S_WRITE;
        end else if (MemRead) begin
          if (hit) begin
            ReadData = data_q[idx];
          end else begin
            busy    = 1'b1;
            state_d = S_FILL;
          end
        end
      end
      S_FILL: begin
        busy     = 1'b1;
        mem_req  = 1'b1;
        mem_addr = addr;
        if (mem_ack) state_d = S_RESP;
      end
      S_WRITE: begin
        busy      = 1'b1;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = addr;
        mem_wdata = WriteData;
        if (mem_ack) state_d = S_RESP;
      end
      S_RESP: begin
        // One non-busy cycle lets the CPU move on before the FSM looks at
        // the request lines again, so the finished request is not reissued.
        if (MemRead && !MemWrite) ReadData = data_q[idx];
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register and valid bits
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_IDLE;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_FILL && mem_ack) valid_q[idx] <= 1'b1;
    end
  end

  // Tag/data arrays have no reset; valid_q alone decides whether a line is
  // usable. Writes are blocked while reset is low, so a late ack is dropped.
  always_ff @(posedge clock) begin
    if (reset) begin
      if (state_q == S_FILL && mem_ack) begin
        tag_q[idx]  <= atag;
        data_q[idx] <= mem_rdata;
      end else if (state_q == S_WRITE && mem_ack && hit) begin
        data_q[idx] <= WriteData;   // write-through; a write miss does not allocate
      end
    end
  end

`ifdef DATA_CACHE_STATS_EN
  logic [15:0] hit_count_q, miss_count_q;
  logic        load_lookup;

  // A load is classified once, when it is first seen in IDLE.
  assign load_lookup = (state_q == S_IDLE) && MemRead && !MemWrite;

  always_ff @(posedge clock) begin
    if (!reset) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else if (load_lookup) begin
      if (hit) begin
        if (hit_count_q != 16'hFFFF) hit_count_q <= hit_count_q + 16'd1;
      end else begin
        if (miss_count_q != 16'hFFFF) miss_count_q <= miss_count_q + 16'd1;
      end
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule
